read_reorder_buffer: RTL and testbench
======================================

# read_reorder_buffer

Parametrised successor of the single-slot-per-ID read reorder buffer. It sits between an upstream AXI-style read master (s_ side) and a downstream interconnect port (m_ side). It forwards AR requests and records their issue order in a circular tracker of DEPTH entries. It accepts R responses from downstream in any inter-ID order and returns them upstream strictly in AR issue order, with RRESP carried and multiple outstanding requests per ID supported.

## Interface
- DATA_WIDTH, 8, R data width
- ID_WIDTH, 4, AR/R ID width
- DEPTH, 8, max outstanding requests; power of two, ≥2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_arid_i  in  ID_WIDTH  upstream AR ID
- s_arvalid_i  in  1  upstream AR valid
- s_arready_o  out  1  upstream AR ready
- s_rdata_o  out  DATA_WIDTH  in-order R data
- s_rid_o  out  ID_WIDTH  in-order R ID
- s_rresp_o  out  2  in-order R response
- s_rvalid_o  out  1  in-order R valid
- s_rready_i  in  1  upstream R ready
- m_arid_o  out  ID_WIDTH  downstream AR ID (= s_arid_i)
- m_arvalid_o  out  1  downstream AR valid
- m_arready_i  in  1  downstream AR ready
- m_rdata_i  in  DATA_WIDTH  downstream R data
- m_rid_i  in  ID_WIDTH  downstream R ID
- m_rresp_i  in  2  downstream R response
- m_rvalid_i  in  1  downstream R valid
- m_rready_o  out  1  downstream R ready
- occupancy_o  out  $clog2(DEPTH+1)  allocated entries
- err_unexpected_o  out  1  one-cycle pulse: R response with no matching pending entry

## Operation
- Tracker: DEPTH entries {alloc, filled, id, data, resp}; head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; count register of $clog2(DEPTH+1) bits. occupancy_o = count.
- Full = (count == DEPTH).
- AR path, combinational:
  - m_arvalid_o = s_arvalid_i & ~full & ~rst.
  - s_arready_o = m_arready_i & ~full & ~rst.
  - m_arid_o = s_arid_i.
- AR handshake (s_arvalid_i & s_arready_o): entry[tail] ← {alloc=1, filled=0, id=s_arid_i}; tail+1.
- R capture: m_rready_o = ~rst (always accept). On m_rvalid_i, scan from head in age order for the oldest entry with alloc=1, filled=0, id==m_rid_i. Write data and resp into it and set filled=1.
  - Same-ID responses therefore fill in issue order.
  - No match: drop the beat and assert err_unexpected_o for that one cycle.
- Scan uses entry state registered at the start of the cycle. An entry allocated in the same cycle is not a match candidate.
- Output: s_rvalid_o = (count≠0) & entry[head].filled. s_rdata_o/s_rid_o/s_rresp_o are driven from entry[head].
- Pop (s_rvalid_o & s_rready_i): clear entry[head].alloc/filled; head+1.
- Simultaneous allocate and pop: count unchanged, both pointers advance. Allocate only: count+1. Pop only: count−1.
- Full is evaluated from registered count. A pop while full does not enable an allocate in the same cycle.
- s_rvalid_o, once high, stays high with stable data/id/resp until the pop (head cannot change otherwise).

## Timing
- AR forwarding: 0 cycles (combinational).
- R latency: m_rvalid_i sampled at edge N → s_rvalid_o visible after edge N (same cycle as entry becomes filled, via registered state), i.e. 1 cycle minimum. This applies only when the filled entry is the head; otherwise the response waits for all older entries to pop.
- Throughput: one allocate, one capture and one pop per cycle, all concurrently.
- Reset (async assert, sync-safe deassert by the system):
  - Clears head, tail, count and every alloc/filled bit.
  - Output values during and after reset: s_arready_o=0, m_arvalid_o=0, m_rready_o=0 while rst; s_rvalid_o=0, s_rdata_o=0, s_rid_o=0, s_rresp_o=0, occupancy_o=0, err_unexpected_o=0.
  - Reset mid-operation discards all outstanding entries. Late downstream responses after reset raise err_unexpected_o.

## Test plan
- Reset, then AR id 2 and id 3 back-to-back. Respond id 3 (0xBF, OKAY) then id 2 (0xFE, OKAY). Required: s_ side returns 0xFE/id2 then 0xBF/id3; occupancy 2→0.
- Two ARs with id 5 then one with id 6. Respond id 6 (0x70), then id 5 (0x11), then id 5 (0x22). Required: output order 0x11, 0x22, 0x70.
- Fill 8 entries with s_rready_i=0 and responses captured. Required: occupancy_o=8, s_arready_o=0, m_arvalid_o=0. Pop one: s_arready_o returns high the next cycle; tail wraps to 0.
- Hold s_rready_i=0 with head filled. Required: s_rdata_o/s_rid_o/s_rresp_o stable. Resp SLVERR (2'b10) on id 4 appears on s_rresp_o unchanged.
- m_rvalid_i with id 9 and no pending id 9. Required: one-cycle err_unexpected_o; occupancy and outputs unchanged.
- Assert rst with 3 outstanding entries. Required: all outputs at reset values immediately. A subsequent response flags err_unexpected_o.

Source files
------------

// File: rtl/read_reorder_buffer.sv
// Read reorder buffer: forwards AR requests, captures R beats in any inter-ID order
// and returns them upstream strictly in AR issue order through a circular tracker.
module read_reorder_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 4,
   parameter int DEPTH      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ID_WIDTH-1:0]          s_arid_i,
   input  logic                         s_arvalid_i,
   output logic                         s_arready_o,
   output logic [DATA_WIDTH-1:0]        s_rdata_o,
   output logic [ID_WIDTH-1:0]          s_rid_o,
   output logic [1:0]                   s_rresp_o,
   output logic                         s_rvalid_o,
   input  logic                         s_rready_i,
   output logic [ID_WIDTH-1:0]          m_arid_o,
   output logic                         m_arvalid_o,
   input  logic                         m_arready_i,
   input  logic [DATA_WIDTH-1:0]        m_rdata_i,
   input  logic [ID_WIDTH-1:0]          m_rid_i,
   input  logic [1:0]                   m_rresp_i,
   input  logic                         m_rvalid_i,
   output logic                         m_rready_o,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
   output logic                         err_unexpected_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DEPTH-1:0]      alloc_q, alloc_d, filled_q, filled_d;
   logic [ID_WIDTH-1:0]   id_q   [DEPTH];
   logic [ID_WIDTH-1:0]   id_d   [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_d [DEPTH];
   logic [1:0]            resp_q [DEPTH];
   logic [1:0]            resp_d [DEPTH];
   logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  err_q, err_d;

   logic          full, do_alloc, do_pop, do_capture, head_filled, hit;
   logic [PW-1:0] hit_idx, scan_idx;

   assign full        = (count_q == DEPTH_C);
   assign s_arready_o = m_arready_i & ~full & ~rst;
   assign m_arvalid_o = s_arvalid_i & ~full & ~rst;
   assign m_arid_o    = s_arid_i;
   assign m_rready_o  = ~rst;
   assign do_alloc    = s_arvalid_i & s_arready_o;

   // Payload is gated so the outputs read zero whenever the head is not valid.
   assign head_filled = (count_q != '0) & filled_q[head_q];
   assign do_pop      = head_filled & s_rready_i;
   assign s_rvalid_o  = head_filled;
   assign s_rdata_o   = head_filled ? data_q[head_q] : '0;
   assign s_rid_o     = head_filled ? id_q[head_q]   : '0;
   assign s_rresp_o   = head_filled ? resp_q[head_q] : '0;
   assign occupancy_o = count_q;
   assign err_unexpected_o = err_q;

   // Age-ordered scan from head: the first hit is the oldest pending entry for this ID.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      scan_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + PW'(i);
         if (!hit && alloc_q[scan_idx] && !filled_q[scan_idx] && (id_q[scan_idx] == m_rid_i)) begin
            hit     = 1'b1;
            hit_idx = scan_idx;
         end
      end
   end

   assign do_capture = m_rvalid_i & m_rready_o & hit;
   assign err_d      = m_rvalid_i & m_rready_o & ~hit;

   // Pop, allocate and capture always touch distinct entries, so their order here is free.
   always_comb begin
      alloc_d  = alloc_q;
      filled_d = filled_q;
      id_d     = id_q;
      data_d   = data_q;
      resp_d   = resp_q;
      head_d   = head_q;
      tail_d   = tail_q;
      if (do_pop) begin
         alloc_d[head_q]  = 1'b0;
         filled_d[head_q] = 1'b0;
         head_d           = head_q + PW'(1);
      end
      if (do_alloc) begin
         alloc_d[tail_q]  = 1'b1;
         filled_d[tail_q] = 1'b0;
         id_d[tail_q]     = s_arid_i;
         tail_d           = tail_q + PW'(1);
      end
      if (do_capture) begin
         filled_d[hit_idx] = 1'b1;
         data_d[hit_idx]   = m_rdata_i;
         resp_d[hit_idx]   = m_rresp_i;
      end
      unique case ({do_alloc, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         alloc_q  <= '0;
         filled_q <= '0;
         err_q    <= 1'b0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         alloc_q  <= alloc_d;
         filled_q <= filled_d;
         err_q    <= err_d;
      end
   end

   // NOTE: payload storage is deliberately not reset; alloc/filled qualify every read.
   always_ff @(posedge clk) begin
      id_q   <= id_d;
      data_q <= data_d;
      resp_q <= resp_d;
   end
endmodule

// File: tb/tb_read_reorder_buffer.sv
// Directed bench for read_reorder_buffer: reordering, same-ID ordering, full/wrap,
// stall stability, unexpected responses and mid-operation reset.
module tb_read_reorder_buffer;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] s_arid_i, s_rid_o, m_arid_o, m_rid_i;
   logic       s_arvalid_i, s_arready_o, s_rvalid_o, s_rready_i;
   logic [7:0] s_rdata_o, m_rdata_i;
   logic [1:0] s_rresp_o, m_rresp_i;
   logic       m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;
   logic [3:0] occupancy_o;
   logic       err_unexpected_o;

   int n_cmp = 0;
   int n_bad = 0;

   read_reorder_buffer dut (
      .clk(clk), .rst(rst),
      .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
      .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o), .s_rresp_o(s_rresp_o),
      .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
      .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
      .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i), .m_rresp_i(m_rresp_i),
      .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
      .occupancy_o(occupancy_o), .err_unexpected_o(err_unexpected_o)
   );

   always #5 clk = ~clk;

   // Stimulus helpers only; every comparison lives in the test tasks.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ar(input logic [3:0] id);
      s_arid_i = id; s_arvalid_i = 1'b1;
      tick();
      s_arvalid_i = 1'b0;
   endtask

   task automatic rsp(input logic [3:0] id, input logic [7:0] data, input logic [1:0] resp);
      m_rid_i = id; m_rdata_i = data; m_rresp_i = resp; m_rvalid_i = 1'b1;
      tick();
      m_rvalid_i = 1'b0;
   endtask

   task automatic pop1();
      s_rready_i = 1'b1;
      tick();
      s_rready_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; s_arvalid_i = 1'b1; s_arid_i = 4'h7;
      #1;
      n_cmp++; if (s_arready_o !== 1'b0) begin n_bad++; $display("FAIL reset_arready got %b want 0", s_arready_o); end
      n_cmp++; if (m_arvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid got %b want 0", m_arvalid_o); end
      n_cmp++; if (m_rready_o !== 1'b0) begin n_bad++; $display("FAIL reset_rready got %b want 0", m_rready_o); end
      n_cmp++; if ({s_rvalid_o, s_rdata_o, s_rid_o, s_rresp_o} !== 15'h0) begin n_bad++; $display("FAIL reset_rout got %b %h %h %b want all 0", s_rvalid_o, s_rdata_o, s_rid_o, s_rresp_o); end
      n_cmp++; if ({occupancy_o, err_unexpected_o} !== 5'h0) begin n_bad++; $display("FAIL reset_occ_err got %0d %b want 0 0", occupancy_o, err_unexpected_o); end
      s_arvalid_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      n_cmp++; if ({s_arready_o, m_rready_o} !== 2'b11) begin n_bad++; $display("FAIL post_reset_ready got %b want 11", {s_arready_o, m_rready_o}); end
   endtask

   task automatic test_reorder();
      s_arid_i = 4'h2; s_arvalid_i = 1'b1;
      #1;
      n_cmp++; if ({m_arvalid_o, m_arid_o} !== 5'h12) begin n_bad++; $display("FAIL ar_forward got %b/%h want 1/2", m_arvalid_o, m_arid_o); end
      tick();
      s_arid_i = 4'h3;
      tick();
      s_arvalid_i = 1'b0;
      n_cmp++; if (occupancy_o !== 4'd2) begin n_bad++; $display("FAIL reorder_occ2 got %0d want 2", occupancy_o); end
      rsp(4'h3, 8'hBF, 2'b00);
      n_cmp++; if (s_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL reorder_wait got %b want 0", s_rvalid_o); end
      rsp(4'h2, 8'hFE, 2'b00);
      n_cmp++; if ({s_rvalid_o, s_rdata_o, s_rid_o} !== {1'b1, 8'hFE, 4'h2}) begin n_bad++; $display("FAIL reorder_first got %b %h %h want 1 fe 2", s_rvalid_o, s_rdata_o, s_rid_o); end
      pop1();
      n_cmp++; if ({s_rvalid_o, s_rdata_o, s_rid_o, occupancy_o} !== {1'b1, 8'hBF, 4'h3, 4'd1}) begin n_bad++; $display("FAIL reorder_second got %b %h %h occ %0d want 1 bf 3 occ 1", s_rvalid_o, s_rdata_o, s_rid_o, occupancy_o); end
      pop1();
      n_cmp++; if ({s_rvalid_o, occupancy_o} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL reorder_drain got %b occ %0d want 0 occ 0", s_rvalid_o, occupancy_o); end
   endtask

   task automatic test_same_id();
      logic [7:0] exp_data [3];
      logic [3:0] exp_id [3];
      exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h70;
      exp_id[0] = 4'h5; exp_id[1] = 4'h5; exp_id[2] = 4'h6;
      ar(4'h5); ar(4'h5); ar(4'h6);
      rsp(4'h6, 8'h70, 2'b00);
      rsp(4'h5, 8'h11, 2'b00);
      rsp(4'h5, 8'h22, 2'b00);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({s_rvalid_o, s_rdata_o, s_rid_o} !== {1'b1, exp_data[i], exp_id[i]}) begin
            n_bad++; $display("FAIL same_id_%0d got %b %h %h want 1 %h %h", i, s_rvalid_o, s_rdata_o, s_rid_o, exp_data[i], exp_id[i]);
         end
         pop1();
      end
      n_cmp++; if (occupancy_o !== 4'd0) begin n_bad++; $display("FAIL same_id_occ got %0d want 0", occupancy_o); end
   endtask

   task automatic test_full_wrap();
      logic [7:0] exp_data;
      do_reset();
      for (int i = 0; i < 8; i++) ar(4'(i));
      s_arid_i = 4'hA; s_arvalid_i = 1'b1;
      #1;
      n_cmp++; if (occupancy_o !== 4'd8) begin n_bad++; $display("FAIL full_occ got %0d want 8", occupancy_o); end
      n_cmp++; if ({s_arready_o, m_arvalid_o} !== 2'b00) begin n_bad++; $display("FAIL full_block got %b want 00", {s_arready_o, m_arvalid_o}); end
      s_arvalid_i = 1'b0;
      for (int i = 7; i >= 0; i--) rsp(4'(i), 8'h80 + 8'(i), 2'b00);
      // Pop while full with an AR pending: no allocate may happen on this edge.
      s_arvalid_i = 1'b1;
      pop1();
      n_cmp++; if ({occupancy_o, s_arready_o, m_arvalid_o} !== {4'd7, 2'b11}) begin n_bad++; $display("FAIL full_pop got occ %0d ready %b valid %b want occ 7 1 1", occupancy_o, s_arready_o, m_arvalid_o); end
      tick();
      s_arvalid_i = 1'b0;
      n_cmp++; if (occupancy_o !== 4'd8) begin n_bad++; $display("FAIL wrap_alloc got %0d want 8", occupancy_o); end
      rsp(4'hA, 8'hAA, 2'b01);
      for (int i = 1; i < 8; i++) begin
         exp_data = 8'h80 + 8'(i);
         n_cmp++;
         if ({s_rvalid_o, s_rdata_o, s_rid_o} !== {1'b1, exp_data, 4'(i)}) begin
            n_bad++; $display("FAIL drain_%0d got %b %h %h want 1 %h %h", i, s_rvalid_o, s_rdata_o, s_rid_o, exp_data, 4'(i));
         end
         pop1();
      end
      n_cmp++; if ({s_rvalid_o, s_rdata_o, s_rid_o, s_rresp_o} !== {1'b1, 8'hAA, 4'hA, 2'b01}) begin n_bad++; $display("FAIL wrap_entry got %b %h %h %b want 1 aa a 01", s_rvalid_o, s_rdata_o, s_rid_o, s_rresp_o); end
      pop1();
      n_cmp++; if (occupancy_o !== 4'd0) begin n_bad++; $display("FAIL wrap_empty got %0d want 0", occupancy_o); end
   endtask

   task automatic test_hold();
      ar(4'h4); ar(4'h1);
      rsp(4'h4, 8'h5A, 2'b10);
      rsp(4'h1, 8'hC3, 2'b00);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({s_rvalid_o, s_rdata_o, s_rid_o, s_rresp_o} !== {1'b1, 8'h5A, 4'h4, 2'b10}) begin
            n_bad++; $display("FAIL hold_%0d got %b %h %h %b want 1 5a 4 10", i, s_rvalid_o, s_rdata_o, s_rid_o, s_rresp_o);
         end
         tick();
      end
      pop1();
      n_cmp++; if ({s_rdata_o, s_rid_o, s_rresp_o} !== {8'hC3, 4'h1, 2'b00}) begin n_bad++; $display("FAIL hold_next got %h %h %b want c3 1 00", s_rdata_o, s_rid_o, s_rresp_o); end
      pop1();
   endtask

   task automatic test_unexpected();
      ar(4'h1);
      rsp(4'h1, 8'h33, 2'b00);
      n_cmp++; if (err_unexpected_o !== 1'b0) begin n_bad++; $display("FAIL unexp_quiet got %b want 0", err_unexpected_o); end
      rsp(4'h9, 8'hEE, 2'b00);
      n_cmp++; if (err_unexpected_o !== 1'b1) begin n_bad++; $display("FAIL unexp_pulse got %b want 1", err_unexpected_o); end
      n_cmp++; if ({occupancy_o, s_rvalid_o, s_rdata_o, s_rid_o} !== {4'd1, 1'b1, 8'h33, 4'h1}) begin n_bad++; $display("FAIL unexp_state got occ %0d %b %h %h want occ 1 1 33 1", occupancy_o, s_rvalid_o, s_rdata_o, s_rid_o); end
      tick();
      n_cmp++; if (err_unexpected_o !== 1'b0) begin n_bad++; $display("FAIL unexp_one_cycle got %b want 0", err_unexpected_o); end
      pop1();
   endtask

   task automatic test_reset_mid();
      ar(4'h1); ar(4'h2); ar(4'h3);
      rsp(4'h1, 8'h44, 2'b00);
      n_cmp++; if ({s_rvalid_o, occupancy_o} !== {1'b1, 4'd3}) begin n_bad++; $display("FAIL mid_pre got %b occ %0d want 1 occ 3", s_rvalid_o, occupancy_o); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({s_rvalid_o, s_rdata_o, s_rid_o, s_rresp_o, occupancy_o} !== 19'h0) begin n_bad++; $display("FAIL mid_reset got %b %h %h %b occ %0d want all 0", s_rvalid_o, s_rdata_o, s_rid_o, s_rresp_o, occupancy_o); end
      n_cmp++; if ({s_arready_o, m_rready_o} !== 2'b00) begin n_bad++; $display("FAIL mid_reset_ready got %b want 00", {s_arready_o, m_rready_o}); end
      tick();
      rst = 1'b0;
      tick();
      rsp(4'h2, 8'h55, 2'b00);
      n_cmp++; if ({err_unexpected_o, occupancy_o, s_rvalid_o} !== {1'b1, 4'd0, 1'b0}) begin n_bad++; $display("FAIL late_resp got err %b occ %0d valid %b want 1 0 0", err_unexpected_o, occupancy_o, s_rvalid_o); end
   endtask

   initial begin
      rst = 1'b1;
      s_arid_i = '0; s_arvalid_i = 1'b0; s_rready_i = 1'b0;
      m_arready_i = 1'b1; m_rdata_i = '0; m_rid_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
      test_reset();
      test_reorder();
      test_same_id();
      test_full_wrap();
      test_hold();
      test_unexpected();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
